// File: rtl/sqrt_share_ctrl.sv
`default_nettype none
// ============================================================================
// sqrt_share_ctrl : round-robin sequencer sharing one iterative sqrt unit
//                   between NUM_REQ requesters, with tagged results and watchdog.
// Revision        : 1.0
// ============================================================================
module sqrt_share_ctrl #(
   parameter  int NUM_REQ = 4,
   parameter  int DIN_W   = 32,
   parameter  int DOUT_W  = 16,
   parameter  int TIMEOUT = 64,
   localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_REQ-1:0]       req_valid,
   input  logic [NUM_REQ*DIN_W-1:0] req_data,
   output logic [NUM_REQ-1:0]       req_ready,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [ID_W-1:0]          rsp_id,
   output logic [DOUT_W-1:0]        rsp_data,
   output logic                     rsp_err,
   output logic                     sq_enable,
   output logic [DIN_W-1:0]         sq_din,
   input  logic [DOUT_W-1:0]        sq_dout,
   input  logic                     sq_valid,
   output logic                     busy
);

   localparam logic [ID_W:0]   NUM_REQ_W  = (ID_W+1)'(NUM_REQ);
   localparam logic [ID_W-1:0] LAST_INIT  = ID_W'(NUM_REQ - 1);
   localparam logic [15:0]     TIMER_LAST = 16'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2,
      S_GAP  = 2'd3
   } state_t;

   state_t            state;
   state_t            next_state;
   logic [ID_W-1:0]   last;
   logic [ID_W-1:0]   grant_idx;
   logic              grant_found;
   logic [ID_W:0]     cand;
   logic [15:0]       timer;
   logic [DIN_W-1:0]  req_word [NUM_REQ];

   generate
      for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
         assign req_word[i]  = req_data[i*DIN_W +: DIN_W];
         assign req_ready[i] = reset && (state == S_IDLE) && grant_found &&
                               (grant_idx == ID_W'(i));
      end
   endgenerate

   // Search upward from the slot after the last grant, wrapping once.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = {1'b0, last} + (ID_W+1)'(k);
         if (cand >= NUM_REQ_W) begin
            cand = cand - NUM_REQ_W;
         end
         if (!grant_found && req_valid[cand[ID_W-1:0]]) begin
            grant_found = 1'b1;
            grant_idx   = cand[ID_W-1:0];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      sq_enable  = 1'b0;
      rsp_valid  = 1'b0;
      busy       = 1'b1;
      case (state)
         S_IDLE: begin
            busy = 1'b0;
            if (grant_found) begin
               next_state = S_WAIT;
            end
         end
         S_WAIT: begin
            sq_enable = 1'b1;
            if (sq_valid || (timer == TIMER_LAST)) begin
               next_state = S_RESP;
            end
         end
         S_RESP: begin
            sq_enable = 1'b1;
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               next_state = S_GAP;
            end
         end
         S_GAP: begin
            // Enable low for this one cycle re-arms the sqrt unit.
            next_state = S_IDLE;
         end
         default: begin
            next_state = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         last     <= LAST_INIT;
         sq_din   <= '0;
         rsp_id   <= '0;
         rsp_data <= '0;
         rsp_err  <= 1'b0;
         timer    <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (grant_found) begin
                  sq_din <= req_word[grant_idx];
                  rsp_id <= grant_idx;
                  last   <= grant_idx;
                  timer  <= '0;
               end
            end
            S_WAIT: begin
               timer <= timer + 16'd1;
               // A result arriving on the final watchdog cycle still wins.
               if (sq_valid) begin
                  rsp_data <= sq_dout;
                  rsp_err  <= 1'b0;
               end else if (timer == TIMER_LAST) begin
                  rsp_data <= '0;
                  rsp_err  <= 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sqrt_share_ctrl.sv
`default_nettype none
// tb_sqrt_share_ctrl : directed + randomized scoreboard bench with a
// behavioural sqrt unit and an abstract round-robin reference model.
module tb_sqrt_share_ctrl;

   localparam int NUM_REQ = 4;
   localparam int DIN_W   = 32;
   localparam int DOUT_W  = 16;
   localparam int TIMEOUT = 64;
   localparam int ID_W    = 2;

   logic                     clk = 1'b0;
   logic                     reset = 1'b0;
   logic [NUM_REQ-1:0]       req_valid = '0;
   logic [NUM_REQ*DIN_W-1:0] req_data = '0;
   logic [NUM_REQ-1:0]       req_ready;
   logic                     rsp_valid;
   logic                     rsp_ready = 1'b1;
   logic [ID_W-1:0]          rsp_id;
   logic [DOUT_W-1:0]        rsp_data;
   logic                     rsp_err;
   logic                     sq_enable;
   logic [DIN_W-1:0]         sq_din;
   logic [DOUT_W-1:0]        sq_dout = '0;
   logic                     sq_valid = 1'b0;
   logic                     busy;

   sqrt_share_ctrl #(
      .NUM_REQ (NUM_REQ),
      .DIN_W   (DIN_W),
      .DOUT_W  (DOUT_W),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_data  (rsp_data),
      .rsp_err   (rsp_err),
      .sq_enable (sq_enable),
      .sq_din    (sq_din),
      .sq_dout   (sq_dout),
      .sq_valid  (sq_valid),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [ID_W-1:0]   id;
      logic [DOUT_W-1:0] data;
      logic              err;
   } rsp_t;

   rsp_t         sb[$];
   int           checks = 0;
   int           failures = 0;
   int           lat_of [NUM_REQ];
   int           cur_lat = 1;
   int           cnt = 0;
   int           phase = 0;
   int           tb_last = NUM_REQ - 1;
   int           cyc = 0;
   int           resp_cyc = 0;
   int           tmo_count = 0;
   int           tmo_seen = 0;
   logic [31:0]  cur_din = '0;
   logic [NUM_REQ-1:0] d_acc;

   function automatic logic [15:0] isqrt(input logic [31:0] x);
      longint r;
      longint xl;
      xl = longint'(x);
      r  = longint'($sqrt(real'(x)));
      while (r * r > xl) r--;
      while ((r + 1) * (r + 1) <= xl) r++;
      return 16'(r);
   endfunction

   function automatic int rr_pick(input logic [NUM_REQ-1:0] pend, input int last);
      for (int k = 1; k <= NUM_REQ; k++) begin
         if (pend[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
      end
      return -1;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural sqrt unit: result appears cur_lat enabled cycles after enable rises.
   always @(posedge clk) begin
      #2;
      if (!sq_enable) begin
         cnt      = 0;
         sq_valid = 1'b0;
      end else begin
         cnt++;
         if (cnt == cur_lat) begin
            sq_valid = 1'b1;
            sq_dout  = isqrt(sq_din);
         end
      end
   end

   // Monitor / scoreboard.
   always begin : monitor
      logic [NUM_REQ-1:0] exp_rr;
      logic               exp_rv;
      int                 pred;
      int                 lat;
      logic [31:0]        d;
      rsp_t               e;
      @(negedge clk or negedge reset);
      #1;
      if (!reset) begin
         chk("rst_req_ready", req_ready, 0);
         chk("rst_busy", busy, 0);
         chk("rst_sq_enable", sq_enable, 0);
         chk("rst_rsp_valid", rsp_valid, 0);
         chk("rst_rsp_fields", {rsp_id, rsp_data, rsp_err}, 0);
         chk("rst_sq_din", sq_din, 0);
         phase   = 0;
         tb_last = NUM_REQ - 1;
         sb.delete();
      end else begin
         cyc++;
         chk("wait_budget", tmo_count, tmo_seen);
         tmo_seen = tmo_count;
         exp_rr = '0;
         pred   = -1;
         if (phase == 0) begin
            pred = rr_pick(req_valid, tb_last);
            if (pred >= 0) exp_rr[pred] = 1'b1;
         end
         exp_rv = (phase == 1) && (cyc >= resp_cyc);
         chk("busy", busy, phase != 0);
         chk("sq_enable", sq_enable, phase == 1);
         chk("req_ready", req_ready, exp_rr);
         chk("rsp_valid", rsp_valid, exp_rv);
         if (rsp_valid) begin
            chk("rsp_sb_nonempty", sb.size() != 0, 1);
            if (sb.size() != 0) chk("rsp_fields", {rsp_id, rsp_data, rsp_err}, sb[0]);
         end
         if (phase == 1) chk("sq_din", sq_din, cur_din);
         case (phase)
            0: if (pred >= 0) begin
                  lat    = lat_of[pred];
                  d      = req_data[pred*DIN_W +: DIN_W];
                  e.id   = ID_W'(pred);
                  e.err  = lat > TIMEOUT;
                  e.data = e.err ? 16'd0 : isqrt(d);
                  sb.push_back(e);
                  cur_din  = d;
                  cur_lat  = lat;
                  tb_last  = pred;
                  resp_cyc = cyc + ((lat > TIMEOUT) ? TIMEOUT : lat) + 1;
                  phase    = 1;
               end
            1: if (exp_rv && rsp_ready) begin
                  if (sb.size() != 0) void'(sb.pop_front());
                  phase = 2;
               end
            default: phase = 0;
         endcase
      end
   end

   task automatic step();
      @(negedge clk);
      d_acc = req_ready & req_valid;
      @(posedge clk);
      #1;
      req_valid = req_valid & ~d_acc;
   endtask

   task automatic raise(input int i, input logic [31:0] d, input int lat);
      req_data[i*DIN_W +: DIN_W] = d;
      lat_of[i]    = lat;
      req_valid[i] = 1'b1;
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      while (!(phase == 0 && req_valid == '0 && sb.size() == 0) && n < budget) begin
         step();
         n++;
      end
      if (n >= budget) tmo_count++;
   endtask

   function automatic int pick_lat();
      if ($urandom_range(0, 7) == 0) return int'($urandom_range(TIMEOUT - 1, TIMEOUT + 2));
      return int'($urandom_range(1, 10));
   endfunction

   initial begin
      for (int i = 0; i < NUM_REQ; i++) lat_of[i] = 1;
      repeat (3) step();
      reset = 1'b1;

      // Contention from reset: expect ids 0,1,2,3 then wrap to 0.
      raise(0, 32'd0, 3);
      raise(1, 32'd1, 3);
      raise(2, 32'd65536, 3);
      raise(3, 32'hFFFF_FFFF, 3);
      wait_idle(500);
      raise(2, 32'd9, 2);
      raise(0, 32'd400, 2);
      wait_idle(200);

      raise(2, 32'd144, 16);
      wait_idle(200);

      // Watchdog, then a normal request.
      raise(1, 32'd1000, 1000);
      wait_idle(300);
      raise(1, 32'd25, 5);
      wait_idle(100);

      // Result on the last watchdog cycle, one cycle late, one cycle early.
      raise(3, 32'd49, TIMEOUT);
      wait_idle(300);
      raise(3, 32'd50, TIMEOUT + 1);
      wait_idle(300);
      raise(0, 32'd81, TIMEOUT - 1);
      wait_idle(300);

      // Backpressure with a competing request.
      rsp_ready = 1'b0;
      raise(1, 32'd10000, 4);
      repeat (4) step();
      raise(2, 32'd77, 2);
      repeat (12) step();
      rsp_ready = 1'b1;
      wait_idle(200);

      repeat (400) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!req_valid[i] && $urandom_range(0, 3) == 0) raise(i, $urandom, pick_lat());
            else if (req_valid[i] && $urandom_range(0, 49) == 0) req_valid[i] = 1'b0;
         end
         rsp_ready = ($urandom_range(0, 3) != 0);
         step();
      end
      rsp_ready = 1'b1;
      wait_idle(3000);

      // Asynchronous reset in the middle of WAIT.
      raise(1, 32'd1234, 40);
      for (int n = 0; n < 50 && req_valid[1]; n++) step();
      repeat (5) step();
      #2;
      reset = 1'b0;
      raise(3, 32'd36, 3);
      raise(0, 32'd4, 3);
      repeat (2) step();
      reset = 1'b1;
      wait_idle(300);

      repeat (3) step();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/sqrt_share_ctrl.md
Name: sqrt_share_ctrl

Overview:
- Round-robin arbiter and sequencer that shares one iterative square-root unit (sqrt or sqrt_nr) between NUM_REQ beamforming requesters, such as per-channel delay calculators.
- Grants one requester at a time and drives the unit's enable/din, holding them until the unit's valid.
- Returns the result tagged with the requester index, with a watchdog timeout so a hung unit cannot stall the beamformer.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- DIN_W, 32, radicand width.
- DOUT_W, 16, root width (DIN_W/2).
- TIMEOUT, 64, max cycles in WAIT before an error response (must be 2..65535).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester request strobe; stays high until accepted.
- req_data  in  NUM_REQ*DIN_W  flattened radicands; requester i uses bits [i*DIN_W +: DIN_W].
- req_ready  out  NUM_REQ  one-hot accept; combinational, high only in IDLE for the granted index.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  max(1,$clog2(NUM_REQ))  index of the requester being answered.
- rsp_data  out  DOUT_W  root result.
- rsp_err  out  1  response produced by timeout; rsp_data is 0.
- sq_enable  out  1  enable to the shared sqrt unit.
- sq_din  out  DIN_W  radicand to the sqrt unit.
- sq_dout  in  DOUT_W  sqrt unit result.
- sq_valid  in  1  sqrt unit result-valid.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset is asynchronous and active-low (reset=0). While reset is asserted:
  - state=IDLE.
  - sq_enable=0, sq_din=0.
  - rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0, busy=0.
  - req_ready=0.
  - last-grant pointer=NUM_REQ-1, so index 0 has highest priority first.
- Reset mid-operation abandons the in-flight request; no response is produced for it.
- FSM states: IDLE, WAIT, RESP, GAP.
- IDLE:
  - If any req_valid is high, grant the first set bit searching from (last+1) mod NUM_REQ upward with wrap.
  - Assert req_ready[g] in that cycle.
  - At the clock edge, capture req_data[g] into sq_din and g into rsp_id, set last=g, clear the timer, and go to WAIT.
  - If no request is pending, stay in IDLE.
- WAIT:
  - sq_enable=1 and sq_din is held stable.
  - The timer increments every cycle.
  - If sq_valid=1: latch rsp_data=sq_dout, rsp_err=0, go to RESP.
  - Else if timer==TIMEOUT-1: rsp_data=0, rsp_err=1, go to RESP.
  - If sq_valid and the timeout occur in the same cycle, sq_valid wins.
- RESP:
  - rsp_valid=1; rsp_id, rsp_data and rsp_err are held stable.
  - When rsp_ready=1, go to GAP (rsp_valid drops next cycle).
  - sq_enable stays 1 through RESP.
- GAP: exactly one cycle with sq_enable=0, which re-arms the sqrt unit; then go to IDLE.
- sq_valid outside WAIT is ignored.
- Latency: request accepted at cycle T; sq_enable=1 from T+1; sq_valid seen at cycle V gives rsp_valid at V+1.
- Minimum request-to-request spacing is unit latency + 3 cycles (accept, RESP, GAP).
- Fairness: with all requesters continuously pending, grants rotate 0,1,…,NUM_REQ-1,0,…
- A requester dropping req_valid before its accept is simply skipped; a request is never lost once accepted.
- No combinational path from any input to sq_enable or sq_din.

Test Plan:
- Single request: req_valid[2]=1, radicand 144, model latency 16 → req_ready[2] pulses one cycle; sq_din=144 with sq_enable=1; rsp_valid with rsp_id=2, rsp_data=12, rsp_err=0 at sq_valid+1.
- Round-robin under contention: all 4 requesters pending with radicands 0, 1, 65536, 0xFFFFFFFF → responses in order id 0,1,2,3 with data 0, 1, 256, 65535; the next grant after id 3 is id 0.
- Timeout: model never asserts sq_valid, TIMEOUT=64 → rsp_err=1, rsp_data=0 after exactly 64 WAIT cycles; the following request completes normally.
- Backpressure: rsp_ready=0 for 10 cycles → rsp_valid and outputs held stable; no new req_ready; one sq_enable=0 GAP cycle after rsp_ready=1.
- Same-cycle valid/timeout: model asserts sq_valid on cycle TIMEOUT-1 of WAIT with dout=7 → rsp_err=0, rsp_data=7.
- Reset mid-WAIT: reset=0 asynchronously → sq_enable, busy and rsp_valid go 0 immediately; after release, requester 0 is granted first and no stale response appears.
